// File: rtl/suspi_cmd_rx.sv
// suspi_cmd_rx - command-side receiver of the SUSPI link.
//
// Deserialises 11-bit frames (start, d0..d7 LSB first, odd parity, stop)
// from COM1 and assembles them into command packets:
//   MARKER, flag, len[15:8], len[7:0], len payload bytes, crc[15:8], crc[7:0]
// CRC is CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflection, no
// final XOR) over everything from the marker to the last payload byte.
//
// Ports
//   bb_clk_in      in   system clock (CLKS_PER_BIT cycles per SUSPI bit)
//   rst_h          in   asynchronous active-high reset
//   COM1           in   serial command line, idles high, asynchronous
//   busy           out  high from an accepted marker until packet end/abort
//   pay_data       out  payload byte, qualified by pay_valid
//   pay_valid      out  1-cycle payload strobe
//   cmd_valid      out  1-cycle strobe: packet complete with a good CRC
//   cmd_flag       out  flag byte of the last good packet
//   cmd_len        out  length field of the last good packet
//   err            out  1-cycle error strobes {to, len, crc, mrk, frm, par}
//   dbg_bit_state  out  bit engine state (IDLE=0, START, BITS, STOP)
//   dbg_pkt_state  out  packet FSM state (P_MARK=0 .. P_CRCL=6)
//
// Handshake: every output strobe (pay_valid, cmd_valid, err) is a single-cycle
// valid with no ready; the consumer must take it in that cycle. pay_valid
// pulses are at least 11 bit times apart. Payload strobed before an abort or
// a CRC error is not retracted; the consumer drops it unless cmd_valid follows.

module suspi_cmd_rx #(
  parameter int          CLKS_PER_BIT = 12,
  parameter logic [7:0]  MARKER       = 8'hA5,
  parameter int          MAX_LEN      = 2032,
  parameter int          TIMEOUT_CLKS = 480
) (
  input  logic        bb_clk_in,
  input  logic        rst_h,
  input  logic        COM1,
  output logic        busy,
  output logic [7:0]  pay_data,
  output logic        pay_valid,
  output logic        cmd_valid,
  output logic [7:0]  cmd_flag,
  output logic [15:0] cmd_len,
  output logic [5:0]  err,
  output logic [1:0]  dbg_bit_state,
  output logic [2:0]  dbg_pkt_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  // ---------------------------------------------------------------------------
  // Synchroniser and start-edge detection
  // ---------------------------------------------------------------------------
  logic       s1, s2, s2_d;
  logic [1:0] fill;
  logic       armed;
  logic       fall;

  // The synchroniser resets to 1, so if the line is already low at reset the
  // first real sample would look like a falling edge. 'fill' marks when s2
  // carries a genuine line sample; 'armed' is set only once that sample is
  // high, so a start needs a real rising edge followed by a falling edge.
  always_ff @(posedge bb_clk_in or posedge rst_h) begin
    if (rst_h) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      s2_d  <= 1'b1;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      s1   <= COM1;
      s2   <= s1;
      s2_d <= s2;
      fill <= {fill[0], 1'b1};
      if (fill[1] && s2) armed <= 1'b1;
    end
  end

  assign fall = armed & s2_d & ~s2;

  // ---------------------------------------------------------------------------
  // Bit engine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {IDLE, START, BITS, STOP} bit_state_t;

  bit_state_t    bst;
  logic [CW-1:0] bcnt;
  logic [3:0]    bidx;
  logic [8:0]    sh;          // {parity, d7..d0} once all 9 bits are in
  logic          byte_rdy;
  logic [7:0]    byte_data;
  logic          byte_par_err;
  logic          byte_frm_err;

  always_ff @(posedge bb_clk_in or posedge rst_h) begin
    if (rst_h) begin
      bst          <= IDLE;
      bcnt         <= '0;
      bidx         <= 4'd0;
      sh           <= 9'd0;
      byte_rdy     <= 1'b0;
      byte_data    <= 8'd0;
      byte_par_err <= 1'b0;
      byte_frm_err <= 1'b0;
    end else begin
      byte_rdy     <= 1'b0;
      byte_par_err <= 1'b0;
      byte_frm_err <= 1'b0;
      case (bst)
        IDLE: begin
          if (fall) begin
            bst  <= START;
            bcnt <= CW'(CLKS_PER_BIT / 2 - 1);
          end
        end
        START: begin
          if (bcnt == '0) begin
            // Still low at mid start bit: real frame. Otherwise a glitch,
            // dropped silently.
            if (!s2) begin
              bst  <= BITS;
              bcnt <= CW'(CLKS_PER_BIT - 1);
              bidx <= 4'd0;
            end else begin
              bst <= IDLE;
            end
          end else begin
            bcnt <= bcnt - CW'(1);
          end
        end
        BITS: begin
          if (bcnt == '0) begin
            sh   <= {s2, sh[8:1]};
            bcnt <= CW'(CLKS_PER_BIT - 1);
            if (bidx == 4'd8) bst <= STOP;
            else              bidx <= bidx + 4'd1;
          end else begin
            bcnt <= bcnt - CW'(1);
          end
        end
        STOP: begin
          if (bcnt == '0) begin
            // Back to IDLE at mid stop bit so a zero-idle next start edge
            // is caught.
            bst          <= IDLE;
            byte_rdy     <= 1'b1;
            byte_data    <= sh[7:0];
            byte_par_err <= ~(^sh);
            byte_frm_err <= ~s2;
          end else begin
            bcnt <= bcnt - CW'(1);
          end
        end
        default: bst <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // CRC-16/CCITT-FALSE, one byte per call
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {P_MARK, P_FLAG, P_LENH, P_LENL, P_DATA, P_CRCH, P_CRCL} pkt_state_t;

  pkt_state_t    pst;
  logic [15:0]   crc_q;
  logic [7:0]    flag_q;
  logic [7:0]    lenh_q;
  logic [15:0]   len_q;
  logic [15:0]   dcnt;
  logic [7:0]    crch_q;
  logic [TW-1:0] to_cnt;
  logic [15:0]   crc_next;
  logic [15:0]   len_rx;

  assign crc_next = crc16_byte(crc_q, byte_data);
  assign len_rx   = {lenh_q, byte_data};

  always_ff @(posedge bb_clk_in or posedge rst_h) begin
    if (rst_h) begin
      pst       <= P_MARK;
      crc_q     <= 16'hFFFF;
      flag_q    <= 8'd0;
      lenh_q    <= 8'd0;
      len_q     <= 16'd0;
      dcnt      <= 16'd0;
      crch_q    <= 8'd0;
      to_cnt    <= '0;
      busy      <= 1'b0;
      pay_data  <= 8'd0;
      pay_valid <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_flag  <= 8'd0;
      cmd_len   <= 16'd0;
      err       <= 6'd0;
    end else begin
      pay_valid <= 1'b0;
      cmd_valid <= 1'b0;
      err       <= 6'd0;
      if (byte_rdy) begin
        // A byte result always wins over a timeout in the same cycle.
        to_cnt <= '0;
        if (byte_par_err || byte_frm_err) begin
          err  <= byte_par_err ? 6'b000001 : 6'b000010;
          pst  <= P_MARK;
          busy <= 1'b0;
        end else begin
          case (pst)
            P_MARK: begin
              if (byte_data == MARKER) begin
                crc_q <= crc16_byte(16'hFFFF, MARKER);
                pst   <= P_FLAG;
                busy  <= 1'b1;
              end else begin
                err <= 6'b000100;
              end
            end
            P_FLAG: begin
              flag_q <= byte_data;
              crc_q  <= crc_next;
              pst    <= P_LENH;
            end
            P_LENH: begin
              lenh_q <= byte_data;
              crc_q  <= crc_next;
              pst    <= P_LENL;
            end
            P_LENL: begin
              crc_q <= crc_next;
              len_q <= len_rx;
              dcnt  <= len_rx;
              if (len_rx > 16'(MAX_LEN)) begin
                err  <= 6'b010000;
                pst  <= P_MARK;
                busy <= 1'b0;
              end else if (len_rx == 16'd0) begin
                pst <= P_CRCH;
              end else begin
                pst <= P_DATA;
              end
            end
            P_DATA: begin
              pay_data  <= byte_data;
              pay_valid <= 1'b1;
              crc_q     <= crc_next;
              dcnt      <= dcnt - 16'd1;
              if (dcnt == 16'd1) pst <= P_CRCH;
            end
            P_CRCH: begin
              crch_q <= byte_data;
              pst    <= P_CRCL;
            end
            P_CRCL: begin
              if ({crch_q, byte_data} == crc_q) begin
                cmd_valid <= 1'b1;
                cmd_flag  <= flag_q;
                cmd_len   <= len_q;
              end else begin
                err <= 6'b001000;
              end
              pst  <= P_MARK;
              busy <= 1'b0;
            end
            default: begin
              pst  <= P_MARK;
              busy <= 1'b0;
            end
          endcase
        end
      end else if (pst != P_MARK) begin
        if (to_cnt == TW'(TIMEOUT_CLKS - 1)) begin
          err    <= 6'b100000;
          pst    <= P_MARK;
          busy   <= 1'b0;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign dbg_bit_state = bst;
  assign dbg_pkt_state = pst;

endmodule

// File: tb/tb_suspi_cmd_rx.sv
`timescale 1ns/1ps
module tb_suspi_cmd_rx;

  localparam int CPB = 12;

  logic        bb_clk_in = 1'b0;
  logic        rst_h;
  logic        COM1;
  logic        busy;
  logic [7:0]  pay_data;
  logic        pay_valid;
  logic        cmd_valid;
  logic [7:0]  cmd_flag;
  logic [15:0] cmd_len;
  logic [5:0]  err;
  logic [1:0]  dbg_bit_state;
  logic [2:0]  dbg_pkt_state;

  suspi_cmd_rx dut (
    .bb_clk_in     (bb_clk_in),
    .rst_h         (rst_h),
    .COM1          (COM1),
    .busy          (busy),
    .pay_data      (pay_data),
    .pay_valid     (pay_valid),
    .cmd_valid     (cmd_valid),
    .cmd_flag      (cmd_flag),
    .cmd_len       (cmd_len),
    .err           (err),
    .dbg_bit_state (dbg_bit_state),
    .dbg_pkt_state (dbg_pkt_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 bb_clk_in = ~bb_clk_in;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard / monitor
  // ---------------------------------------------------------------------------
  logic [7:0]  exp_q[$];
  int          n_cmd;
  int          n_pay;
  int          err_cnt[6];
  logic [7:0]  last_flag;
  logic [15:0] last_len;

  always @(negedge bb_clk_in) begin
    if (!rst_h) begin
      if (pay_valid) begin
        n_pay++;
        if (exp_q.size() == 0) check("pay_unexpected", 32'(exp_q.size()), 32'd1);
        else                   check("pay_data", {24'd0, pay_data}, {24'd0, exp_q.pop_front()});
      end
      if (cmd_valid) begin
        n_cmd++;
        last_flag = cmd_flag;
        last_len  = cmd_len;
      end
      for (int i = 0; i < 6; i++) if (err[i]) err_cnt[i]++;
      if (err != 6'd0) check("err_onehot", 32'($countones(err)), 32'd1);
    end
  end

  task automatic clear_mon();
    n_cmd = 0;
    n_pay = 0;
    for (int i = 0; i < 6; i++) err_cnt[i] = 0;
    exp_q.delete();
  endtask

  function automatic int err_total();
    int s;
    s = 0;
    for (int i = 0; i < 6; i++) s += err_cnt[i];
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  logic [7:0] tx_q[$];
  logic [7:0] pay_in[$];

  task automatic idle(input int n);
    COM1 = 1'b1;
    repeat (n) @(negedge bb_clk_in);
  endtask

  task automatic send_bit(input logic b);
    COM1 = b;
    repeat (CPB) @(negedge bb_clk_in);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    logic p;
    p = (~^d) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(~bad_stop);
  endtask

  // Bit-serial reference CRC-16/CCITT-FALSE over tx_q.
  function automatic logic [15:0] calc_crc();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (tx_q[k]) begin
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ tx_q[k][j];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic send_pkt(input logic [7:0] flag, input logic [15:0] len, input logic [7:0] crc_xor);
    logic [15:0] crc;
    tx_q.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(flag);
    tx_q.push_back(len[15:8]);
    tx_q.push_back(len[7:0]);
    foreach (pay_in[k]) tx_q.push_back(pay_in[k]);
    crc = calc_crc();
    tx_q.push_back(crc[15:8]);
    tx_q.push_back(crc[7:0] ^ crc_xor);
    foreach (tx_q[k]) send_frame(tx_q[k], 1'b0, 1'b0);
    idle(24);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    COM1  = 1'b1;
    rst_h = 1'b1;
    clear_mon();
    repeat (5) @(negedge bb_clk_in);

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pay_valid", {31'd0, pay_valid}, 32'd0);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_cmd_flag", {24'd0, cmd_flag}, 32'd0);
    check("rst_cmd_len", {16'd0, cmd_len}, 32'd0);
    check("rst_err", {26'd0, err}, 32'd0);
    rst_h = 1'b0;
    idle(20);

    // Status request
    clear_mon();
    pay_in.delete();
    send_pkt(8'h03, 16'h0000, 8'h00);
    check("status_cmd", n_cmd, 32'd1);
    check("status_flag", {24'd0, last_flag}, 32'h03);
    check("status_len", {16'd0, last_len}, 32'd0);
    check("status_err", err_total(), 32'd0);
    check("status_pay", n_pay, 32'd0);
    check("status_busy", {31'd0, busy}, 32'd0);

    // Payload, sent back to back with zero idle
    clear_mon();
    pay_in = '{8'h11, 8'h22, 8'h33};
    exp_q  = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h04, 16'h0003, 8'h00);
    check("pay_count", n_pay, 32'd3);
    check("pay_cmd", n_cmd, 32'd1);
    check("pay_flag", {24'd0, last_flag}, 32'h04);
    check("pay_len", {16'd0, last_len}, 32'd3);
    check("pay_err", err_total(), 32'd0);
    check("pay_left", 32'(exp_q.size()), 32'd0);
    pay_in.delete();

    // Bad parity in the flag byte
    clear_mon();
    send_frame(8'hA5, 1'b0, 1'b0);
    check("par_busy_hi", {31'd0, busy}, 32'd1);
    send_frame(8'h03, 1'b1, 1'b0);
    idle(24);
    check("par_err", err_cnt[0], 32'd1);
    check("par_busy_lo", {31'd0, busy}, 32'd0);
    check("par_no_cmd", n_cmd, 32'd0);
    clear_mon();
    send_pkt(8'h03, 16'h0000, 8'h00);
    check("par_recover_cmd", n_cmd, 32'd1);
    check("par_recover_err", err_total(), 32'd0);

    // Stop bit 0
    clear_mon();
    send_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'h03, 1'b0, 1'b1);
    idle(24);
    check("frm_err", err_cnt[1], 32'd1);
    check("frm_err_total", err_total(), 32'd1);
    check("frm_busy", {31'd0, busy}, 32'd0);

    // Leading wrong marker
    clear_mon();
    send_frame(8'h5A, 1'b0, 1'b0);
    send_pkt(8'h03, 16'h0000, 8'h00);
    check("mrk_err", err_cnt[2], 32'd1);
    check("mrk_cmd", n_cmd, 32'd1);

    // Corrupted CRC low byte
    clear_mon();
    send_pkt(8'h03, 16'h0000, 8'h01);
    check("crc_err", err_cnt[3], 32'd1);
    check("crc_err_total", err_total(), 32'd1);
    check("crc_no_cmd", n_cmd, 32'd0);

    // Length just above MAX_LEN
    clear_mon();
    send_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'h03, 1'b0, 1'b0);
    send_frame(8'h07, 1'b0, 1'b0);
    send_frame(8'hF1, 1'b0, 1'b0);
    idle(24);
    check("len_err", err_cnt[4], 32'd1);
    check("len_err_total", err_total(), 32'd1);
    check("len_busy", {31'd0, busy}, 32'd0);
    check("len_state", {29'd0, dbg_pkt_state}, 32'd0);

    // Timeout
    clear_mon();
    send_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'h03, 1'b0, 1'b0);
    idle(400);
    check("to_early", err_cnt[5], 32'd0);
    check("to_busy_hi", {31'd0, busy}, 32'd1);
    idle(200);
    check("to_err", err_cnt[5], 32'd1);
    check("to_busy_lo", {31'd0, busy}, 32'd0);
    check("to_state", {29'd0, dbg_pkt_state}, 32'd0);

    // 3-cycle glitch
    clear_mon();
    COM1 = 1'b0;
    repeat (3) @(negedge bb_clk_in);
    idle(200);
    check("glitch_err", err_total(), 32'd0);
    check("glitch_cmd", n_cmd, 32'd0);
    check("glitch_bit_state", {30'd0, dbg_bit_state}, 32'd0);
    check("glitch_pkt_state", {29'd0, dbg_pkt_state}, 32'd0);

    // Reset in the middle of the length-high byte, released with line low
    clear_mon();
    send_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'h03, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rst_h = 1'b1;
    repeat (3) @(negedge bb_clk_in);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_flag", {24'd0, cmd_flag}, 32'd0);
    check("mid_rst_len", {16'd0, cmd_len}, 32'd0);
    check("mid_rst_err", {26'd0, err}, 32'd0);
    check("mid_rst_pkt_state", {29'd0, dbg_pkt_state}, 32'd0);
    rst_h = 1'b0;
    repeat (30) @(negedge bb_clk_in);
    idle(200);
    check("post_rst_err", err_total(), 32'd0);
    check("post_rst_bit_state", {30'd0, dbg_bit_state}, 32'd0);
    send_pkt(8'h07, 16'h0000, 8'h00);
    check("post_rst_cmd", n_cmd, 32'd1);
    check("post_rst_flag", {24'd0, last_flag}, 32'h07);
    check("post_rst_err2", err_total(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
